// File: rtl/minirv_dbus_bridge.sv
// minirv_dbus_bridge: data-bus bridge between the miniRV load/store port and the SoC data side.
//
// A request is accepted in IDLE and decoded as one of three kinds:
//   - DRAM: asynchronous-read, synchronous-write word memory. Sub-word stores are done as
//     read-modify-write.
//   - Peripheral: N_DEV word-only channels at 0xFFFF_x000. The bridge waits for the channel's
//     ready signal and gives up after TIMEOUT wait cycles.
//   - Error: a misaligned request, an illegal size, or an unmapped address.
// Every request produces exactly one single-cycle response.
//
// Ports
//   cpu_clk, cpu_rst_n        clock and asynchronous active-low reset
//   req_*                     CPU request; req_ready is high only in IDLE
//   rsp_valid/rdata/err       one-cycle response; rdata and err hold until the next response
//   err_cnt                   saturating count of error responses
//   mem_a/spo/we/d            DRAM word port
//   per_sel/we/addr/wdata     peripheral request, one-hot channel select
//   per_rdata/per_ready       per-channel read data and completion
module minirv_dbus_bridge #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned N_DEV   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [7:0]            err_cnt,
  output logic [ADDR_W-1:0]     mem_a,
  input  logic [DATA_W-1:0]     mem_spo,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_d,
  output logic [N_DEV-1:0]      per_sel,
  output logic                  per_we,
  output logic [11:0]           per_addr,
  output logic [DATA_W-1:0]     per_wdata,
  input  logic [N_DEV*32-1:0]   per_rdata,
  input  logic [N_DEV-1:0]      per_ready
);

  // Only the low address bits are needed after acceptance: the word address for DRAM and the
  // channel index plus register offset for peripherals.
  localparam int unsigned AqW = (ADDR_W + 2 > 16) ? ADDR_W + 2 : 16;

  typedef enum logic [2:0] {
    StIdle,
    StMemRd,
    StMemWr,
    StPerWait,
    StResp
  } state_e;

  state_e             state_q, state_d;
  logic [AqW-1:0]     addr_q, addr_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               mem_we_q, mem_we_d;
  logic [N_DEV-1:0]   per_sel_q, per_sel_d;
  logic               per_we_q, per_we_d;

  // Extract and extend a byte or half from a DRAM word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'd0:    res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte or half of the old word with right-aligned store data.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [1:0] size);
    logic [31:0] res;
    res = old;
    case (size)
      2'd0: begin
        case (off)
          2'd0:    res[7:0]   = wd[7:0];
          2'd1:    res[15:8]  = wd[7:0];
          2'd2:    res[23:16] = wd[7:0];
          default: res[31:24] = wd[7:0];
        endcase
      end
      2'd1: begin
        if (off[1]) res[31:16] = wd[15:0];
        else        res[15:0]  = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  // Request decode on the incoming request, so the error path can respond the next cycle.
  logic misalign, is_per_rgn, per_idx_ok, is_dram, dec_err;

  always_comb begin
    misalign   = (req_size == 2'd3) ||
                 (req_size == 2'd1 && req_addr[0]) ||
                 (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    is_per_rgn = (req_addr[31:16] == 16'hFFFF);
    per_idx_ok = (32'(req_addr[15:12]) < N_DEV);
    is_dram    = ((req_addr >> (ADDR_W + 2)) == 32'd0);
    dec_err    = misalign ||
                 (is_per_rgn && (!per_idx_ok || req_size != 2'd2)) ||
                 (!is_per_rgn && !is_dram);
  end

  // Selected peripheral channel; other channels' ready bits are ignored.
  logic [31:0] per_rd;
  logic        per_rdy;

  always_comb begin
    per_rd  = '0;
    per_rdy = 1'b0;
    for (int i = 0; i < int'(N_DEV); i++) begin
      if (addr_q[15:12] == 4'(i)) begin
        per_rd  = per_rdata[32*i +: 32];
        per_rdy = per_ready[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    err_cnt_d = err_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr[AqW-1:0];
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata;
          cnt_d   = '0;
          if (dec_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end else if (is_per_rgn) begin
            state_d = StPerWait;
          end else if (req_we && req_size == 2'd2) begin
            state_d = StMemWr;
          end else begin
            // Loads, and sub-word stores that must fetch the old word first.
            state_d = StMemRd;
          end
        end
      end
      StMemRd: begin
        if (we_q) begin
          wdata_d = store_merge(mem_spo, wdata_q, addr_q[1:0], size_q);
          state_d = StMemWr;
        end else begin
          rdata_d = load_extract(mem_spo, addr_q[1:0], size_q, uns_q);
          err_d   = 1'b0;
          state_d = StResp;
        end
      end
      StMemWr: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = StResp;
      end
      StPerWait: begin
        // Ready wins over a timeout reached on the same cycle.
        if (per_rdy) begin
          rdata_d = we_q ? 32'd0 : per_rd;
          err_d   = 1'b0;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(TIMEOUT)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_q != StResp && state_d == StResp && err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end

    // Strobes are registered from the next state so they are glitch-free flop outputs.
    rsp_valid_d = (state_d == StResp);
    mem_we_d    = (state_d == StMemWr);
    per_we_d    = (state_d == StPerWait) && we_d;
    for (int i = 0; i < int'(N_DEV); i++) begin
      per_sel_d[i] = (state_d == StPerWait) && (addr_d[15:12] == 4'(i));
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      rsp_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      per_sel_q   <= '0;
      per_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      mem_we_q    <= mem_we_d;
      per_sel_q   <= per_sel_d;
      per_we_q    <= per_we_d;
    end
  end

  // Held low during reset even though the state register already reads IDLE.
  assign req_ready = cpu_rst_n && (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign err_cnt   = err_cnt_q;
  assign mem_a     = addr_q[ADDR_W+1:2];
  assign mem_we    = mem_we_q;
  assign mem_d     = wdata_q;
  assign per_sel   = per_sel_q;
  assign per_we    = per_we_q;
  assign per_addr  = addr_q[11:0];
  assign per_wdata = wdata_q;

endmodule

// File: tb/tb_minirv_dbus_bridge.sv
module tb_minirv_dbus_bridge;

  logic         cpu_clk = 1'b0;
  logic         cpu_rst_n;
  logic         req_valid, req_ready, req_we, req_unsigned;
  logic [31:0]  req_addr, req_wdata;
  logic [1:0]   req_size;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;
  logic [7:0]   err_cnt;
  logic [13:0]  mem_a;
  logic [31:0]  mem_spo, mem_d;
  logic         mem_we;
  logic [3:0]   per_sel;
  logic         per_we;
  logic [11:0]  per_addr;
  logic [31:0]  per_wdata;
  logic [127:0] per_rdata;
  logic [3:0]   per_ready = '0;

  minirv_dbus_bridge #(
    .ADDR_W (14),
    .DATA_W (32),
    .N_DEV  (4),
    .TIMEOUT(15)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst_n   (cpu_rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .err_cnt     (err_cnt),
    .mem_a       (mem_a),
    .mem_spo     (mem_spo),
    .mem_we      (mem_we),
    .mem_d       (mem_d),
    .per_sel     (per_sel),
    .per_we      (per_we),
    .per_addr    (per_addr),
    .per_wdata   (per_wdata),
    .per_rdata   (per_rdata),
    .per_ready   (per_ready)
  );

  always #5 cpu_clk = ~cpu_clk;

  int cyc = 0;
  always @(posedge cpu_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // DRAM: asynchronous read, synchronous write.
  logic [31:0] dram [16384];
  assign mem_spo = dram[mem_a];
  always @(posedge cpu_clk) if (mem_we) dram[mem_a] <= mem_d;

  // Peripherals: channel 2 returns the interesting value, the others a marker.
  assign per_rdata = {32'hBAD0_0003, 32'hCAFE_0001, 32'hBAD0_0001, 32'hBAD0_0000};

  int          per_delay = -1;  // ready after this many wait cycles; -1 = never
  int          wcnt = 0;
  int          wmax = 0;
  logic [3:0]  sel_seen;
  logic [11:0] paddr_seen;
  logic        pwe_seen;
  logic [31:0] pwd_seen;

  always @(negedge cpu_clk) begin
    if (per_sel != 4'b0) begin
      wcnt++;
      if (wcnt == 1) begin
        sel_seen   = per_sel;
        paddr_seen = per_addr;
        pwe_seen   = per_we;
        pwd_seen   = per_wdata;
      end
      if (wcnt > wmax) wmax = wcnt;
      // Unselected channels look ready to confirm they are ignored.
      per_ready = (per_delay >= 0 && wcnt > per_delay) ? per_sel : ~per_sel;
    end else begin
      wcnt      = 0;
      per_ready = 4'b0;
    end
  end

  // Scoreboard and monitor.
  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int          we_cnt = 0;
  int          we_cyc;
  logic [13:0] we_a;
  logic [31:0] we_d;

  always @(negedge cpu_clk) begin
    if (cpu_rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_valid=1 rdata=0x%08h, expected no response", rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, e.rd);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        check("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (mem_we) begin
      we_cnt++;
      we_cyc = cyc;
      we_a   = mem_a;
      we_d   = mem_d;
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input bit push, output int t);
    @(negedge cpu_clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge cpu_clk);
    if (!req_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: req_ready=0 for 20 cycles, expected 1");
    end
    t = cyc;
    if (push) exp_q.push_back('{rd: exp_rd, err: exp_err, cyc: t + lat});
    @(posedge cpu_clk);
    #1;
    // Scramble the request inputs so any use of them after acceptance shows up.
    req_valid    = 1'b0;
    req_we       = ~we;
    req_addr     = 32'hFFFF_FFFF;
    req_size     = 2'd3;
    req_unsigned = ~uns;
    req_wdata    = 32'hFFFF_FFFF;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge cpu_clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_err, input int lat, output int t);
    issue(we, addr, size, uns, wd, exp_rd, exp_err, lat, 1'b1, t);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  int t;
  int we_save;

  initial begin
    for (int i = 0; i < 16384; i++) dram[i] = 32'h0;
    cpu_rst_n    = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;

    // Reset state.
    repeat (2) @(negedge cpu_clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_per_sel", {28'b0, per_sel}, 32'd0);
    check("rst_per_we", {31'b0, per_we}, 32'd0);
    cpu_rst_n = 1'b1;

    // Word store then word load.
    xfer(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, t);
    check("wst_we_count", 32'(we_cnt), 32'd1);
    check("wst_we_cycle", 32'(we_cyc), 32'(t + 1));
    check("wst_mem_a", {18'b0, we_a}, 32'd4);
    check("wst_mem_d", we_d, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h0000_0010, 2'd2, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, t);

    // Byte store via read-modify-write, then sub-word loads.
    xfer(1'b1, 32'h0000_0010, 2'd2, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 2, t);
    xfer(1'b1, 32'h0000_0013, 2'd0, 1'b0, 32'h0000_005A, 32'h0, 1'b0, 3, t);
    check("bst_we_cycle", 32'(we_cyc), 32'(t + 2));
    check("bst_mem_d", we_d, 32'h5A22_3344);
    check("bst_dram", dram[4], 32'h5A22_3344);
    xfer(1'b0, 32'h0000_0013, 2'd0, 1'b0, 32'h0, 32'h0000_005A, 1'b0, 2, t);
    xfer(1'b0, 32'h0000_0012, 2'd1, 1'b0, 32'h0, 32'h0000_5A22, 1'b0, 2, t);
    xfer(1'b0, 32'h0000_0012, 2'd1, 1'b1, 32'h0, 32'h0000_5A22, 1'b0, 2, t);

    // Negative byte: sign and zero extension.
    xfer(1'b1, 32'h0000_0011, 2'd0, 1'b0, 32'hFFFF_FF80, 32'h0, 1'b0, 3, t);
    check("neg_dram", dram[4], 32'h5A22_8044);
    xfer(1'b0, 32'h0000_0011, 2'd0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 2, t);
    xfer(1'b0, 32'h0000_0011, 2'd0, 1'b1, 32'h0, 32'h0000_0080, 1'b0, 2, t);
    xfer(1'b0, 32'h0000_0010, 2'd1, 1'b0, 32'h0, 32'hFFFF_8044, 1'b0, 2, t);

    // Error paths: no DRAM write, response the cycle after acceptance.
    we_save = we_cnt;
    xfer(1'b0, 32'h0000_0001, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, 1, t);
    check("err1_cnt", {24'b0, err_cnt}, 32'd1);
    xfer(1'b1, 32'h0000_0002, 2'd2, 1'b0, 32'h1, 32'h0, 1'b1, 1, t);
    check("err2_cnt", {24'b0, err_cnt}, 32'd2);
    xfer(1'b1, 32'h0000_0000, 2'd3, 1'b0, 32'h2, 32'h0, 1'b1, 1, t);
    check("err3_cnt", {24'b0, err_cnt}, 32'd3);
    xfer(1'b1, 32'h0001_0000, 2'd2, 1'b0, 32'h3, 32'h0, 1'b1, 1, t);
    check("err4_cnt", {24'b0, err_cnt}, 32'd4);
    check("err_no_we", 32'(we_cnt), 32'(we_save));

    // Peripheral read, ready after three wait cycles.
    per_delay = 3;
    wmax = 0;
    xfer(1'b0, 32'hFFFF_2004, 2'd2, 1'b0, 32'h0, 32'hCAFE_0001, 1'b0, 5, t);
    check("per_sel", {28'b0, sel_seen}, 32'h4);
    check("per_addr", {20'b0, paddr_seen}, 32'h004);
    check("per_we_rd", {31'b0, pwe_seen}, 32'd0);
    check("per_wait", 32'(wmax), 32'd4);

    // Peripheral write, ready on the first wait cycle.
    per_delay = 0;
    wmax = 0;
    xfer(1'b1, 32'hFFFF_1008, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 2, t);
    check("pwr_sel", {28'b0, sel_seen}, 32'h2);
    check("pwr_addr", {20'b0, paddr_seen}, 32'h008);
    check("pwr_we", {31'b0, pwe_seen}, 32'd1);
    check("pwr_wdata", pwd_seen, 32'h1234_5678);

    // Ready arrives as the counter reaches TIMEOUT: success.
    per_delay = 14;
    wmax = 0;
    xfer(1'b0, 32'hFFFF_2000, 2'd2, 1'b0, 32'h0, 32'hCAFE_0001, 1'b0, 16, t);
    check("edge_wait", 32'(wmax), 32'd15);
    check("edge_err_cnt", {24'b0, err_cnt}, 32'd4);

    // Ready never comes: timeout error.
    per_delay = -1;
    wmax = 0;
    xfer(1'b0, 32'hFFFF_2004, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 16, t);
    check("tmo_wait", 32'(wmax), 32'd15);
    check("tmo_err_cnt", {24'b0, err_cnt}, 32'd5);

    // Peripheral index out of range and non-word peripheral access.
    wmax = 0;
    xfer(1'b0, 32'hFFFF_5000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1, t);
    check("bad_idx_cnt", {24'b0, err_cnt}, 32'd6);
    xfer(1'b0, 32'hFFFF_1002, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, 1, t);
    check("per_half_cnt", {24'b0, err_cnt}, 32'd7);
    check("per_err_no_sel", 32'(wmax), 32'd0);

    // Reset in MEM_RD of a sub-word store aborts without writing.
    xfer(1'b1, 32'h0000_0020, 2'd2, 1'b0, 32'hA5A5_A5A5, 32'h0, 1'b0, 2, t);
    we_save = we_cnt;
    issue(1'b1, 32'h0000_0021, 2'd0, 1'b0, 32'h0000_00FF, 32'h0, 1'b0, 0, 1'b0, t);
    cpu_rst_n = 1'b0;
    #1;
    check("arst_req_ready", {31'b0, req_ready}, 32'd0);
    check("arst_mem_we", {31'b0, mem_we}, 32'd0);
    check("arst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("arst_err_cnt", {24'b0, err_cnt}, 32'd0);
    check("arst_rsp_rdata", rsp_rdata, 32'd0);
    repeat (3) @(negedge cpu_clk);
    cpu_rst_n = 1'b1;
    @(negedge cpu_clk);
    check("arst_ready_after", {31'b0, req_ready}, 32'd1);
    check("arst_no_we", 32'(we_cnt), 32'(we_save));
    check("arst_dram", dram[8], 32'hA5A5_A5A5);
    xfer(1'b0, 32'h0000_0020, 2'd2, 1'b0, 32'h0, 32'hA5A5_A5A5, 1'b0, 2, t);

    // err_cnt saturates.
    for (int i = 0; i < 260; i++) begin
      xfer(1'b0, 32'h0000_0000, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 1, t);
    end
    check("err_cnt_sat", {24'b0, err_cnt}, 32'd255);

    repeat (2) @(negedge cpu_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/minirv_dbus_bridge.md
Name: minirv_dbus_bridge

Overview:
- Parametrised data-bus bridge between the miniRV core's load/store port and the data side of the SoC.
- Replaces the direct core-to-DRAM wiring. Adds a valid/ready handshake, sub-word loads and stores (read-modify-write), and misalignment and unmapped-address errors.
- Adds N_DEV memory-mapped peripheral channels with wait-state handling and a timeout.
- DRAM keeps its asynchronous-read, synchronous-write interface.

Parameters:
- ADDR_W, 14, DRAM word-address width (DRAM holds 2^ADDR_W words).
- DATA_W, 32, data width; only 32 is supported.
- N_DEV, 4, number of peripheral channels (1..16).
- TIMEOUT, 15, peripheral wait cycles before a bus error (1..255).

Ports:
- cpu_clk  in  1  single clock; all state changes on the rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  CPU request valid.
- req_ready  out  1  bridge accepts the request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  in  1  zero-extend loads.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load data, aligned and extended; 0 for stores and errors.
- rsp_err  out  1  bus error, qualified by rsp_valid.
- err_cnt  out  8  saturating count of error responses.
- mem_a  out  ADDR_W  DRAM word address.
- mem_spo  in  32  DRAM asynchronous read data.
- mem_we  out  1  DRAM write enable.
- mem_d  out  32  DRAM write data.
- per_sel  out  N_DEV  one-hot peripheral select.
- per_we  out  1  peripheral write.
- per_addr  out  12  peripheral register offset (req_addr[11:0]).
- per_wdata  out  32  peripheral write data.
- per_rdata  in  N_DEV*32  per-channel read data; channel i is bits [32i+31:32i].
- per_ready  in  N_DEV  per-channel completion.

Behaviour:
- Reset: state IDLE; req_ready=0 while cpu_rst_n=0; rsp_valid=0, rsp_rdata=0, rsp_err=0, err_cnt=0, mem_we=0, per_sel=0, per_we=0. A reset during any state aborts the operation immediately and performs no further DRAM write.
- Handshake: req_ready=1 only in IDLE (out of reset). Acceptance happens at cycle T when req_valid&req_ready. The bridge latches addr, we, size, unsigned and wdata at T and ignores request inputs until it returns to IDLE.
- Decode, evaluated in this order on the latched request:
  - size==3, or misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> ERR.
  - addr[31:16]==16'hFFFF -> peripheral. Index = addr[15:12]; index>=N_DEV or size!=2 -> ERR.
  - addr[31:ADDR_W+2]==0 -> DRAM, mem_a = addr[ADDR_W+1:2].
  - Otherwise -> ERR.
- FSM states: IDLE, MEM_RD, MEM_WR, PER_WAIT, RESP.
- DRAM load: T+1 MEM_RD captures mem_spo; T+2 RESP. Byte/half is selected by addr[1:0] and sign- or zero-extended.
- DRAM word store: T+1 MEM_WR (mem_we=1, mem_d=wdata); T+2 RESP.
- DRAM sub-word store: T+1 MEM_RD (old word); T+2 MEM_WR with the merged word, only the addressed byte(s) replaced; T+3 RESP.
- Peripheral: from T+1, stay in PER_WAIT with per_sel[index]=1 and per_we/per_addr/per_wdata held.
  - Each PER_WAIT cycle, sample per_ready[index] (other bits ignored). When high: capture per_rdata channel, go to RESP next cycle.
  - The wait counter starts at 0 and increments each PER_WAIT cycle without ready. Reaching TIMEOUT -> RESP with rsp_err=1; per_sel drops.
  - Ready arriving on the same cycle the counter reaches TIMEOUT counts as success.
- ERR path: T+1 RESP, rsp_err=1, rsp_rdata=0. No DRAM or peripheral strobe is asserted.
- RESP: lasts one cycle, then IDLE; rsp_valid=1 only in RESP. rsp_rdata/rsp_err hold until the next RESP.
- mem_we is high only in MEM_WR. mem_a is driven from the latched address in MEM_RD/MEM_WR and is don't-care otherwise.
- err_cnt increments on each error RESP and saturates at 255.

Test Plan:
- Word store 0xDEADBEEF @0x00000010, then word load @0x10 -> mem_we pulse at T+1 with mem_a=4; load rsp_valid at T+2 with rdata=0xDEADBEEF, err=0.
- Byte store 0x5A @0x13 over 0x11223344, then signed byte load @0x13 and half load @0x12 (signed and unsigned) -> word becomes 0x5A223344; byte load=0x0000005A; half load=0x00005A22.
- Store 0x80 byte @0x11, signed byte load -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half load @0x01, word load @0x02, size=3, and addr 0x00010000 (ADDR_W=14) -> each gives rsp_err=1 at T+1, no mem_we, err_cnt 1..4.
- Peripheral read @0xFFFF2004 with per_ready[2] raised after 3 cycles, rdata 0xCAFE0001 -> per_sel=4'b0100, per_addr=0x004; response at T+5, err=0. Repeat with per_ready never raised -> rsp_err=1 after TIMEOUT=15 wait cycles. @0xFFFF5000 with N_DEV=4 -> immediate error.
- Assert cpu_rst_n low during MEM_RD of a sub-word store -> no mem_we pulse, outputs reset immediately; after release, req_ready=1 and DRAM contents are unchanged.
